// File: rtl/negate_arbiter.sv
// negate_arbiter: round-robin share of one 8-bit negator among N_REQ valid/ready requesters, one op in flight, registered response + done_cnt
module twos_compliment (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = ~a + 8'd1;
endmodule

module negate_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic                 rsp_ovf,
  output logic                 rsp_zero,
  output logic [15:0]          done_cnt
);
  typedef enum logic {IDLE, RESP} state_t;
  localparam logic [ID_W:0] NR = (ID_W+1)'(N_REQ);
  state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, win, idx;
  logic [ID_W:0] s;
  logic [7:0] op_q, op_d, sel;
  logic ovf_q, ovf_d, zero_q, zero_d, found;
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    win = '0;
    found = 1'b0;
    s = '0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      s = {1'b0, ptr_q} + (ID_W+1)'(k);
      idx = ID_W'(s >= NR ? s - NR : s);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign sel = req_data[{win, 3'b000} +: 8];
  assign req_ready = (rst_n && state_q == IDLE && found) ? N_REQ'(1) << win : '0;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    op_d = op_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && found) begin
      state_d = RESP;
      id_d = win;
      op_d = sel;
      ovf_d = sel == 8'h80;
      zero_d = sel == 8'h00;
      ptr_d = (win == ID_W'(N_REQ-1)) ? '0 : win + ID_W'(1);
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
      cnt_d = cnt_q + 16'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      op_q <= '0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      op_q <= op_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
      cnt_q <= cnt_d;
    end
  end
  twos_compliment u_neg (.a(op_q), .y(rsp_data));
  assign rsp_valid = state_q == RESP;
  assign rsp_id = id_q;
  assign rsp_ovf = ovf_q;
  assign rsp_zero = zero_q;
  assign done_cnt = cnt_q;
endmodule

// File: tb/tb_negate_arbiter.sv
// tb_negate_arbiter: scoreboard bench with behavioural arbitration/negation model
module tb_negate_arbiter;
  localparam int N = 4;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [W-1:0] rsp_id;
  logic [7:0] rsp_data;
  logic rsp_ovf, rsp_zero;
  logic [15:0] done_cnt;
  negate_arbiter #(.N_REQ(N), .ID_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero),
    .done_cnt(done_cnt)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [1:0] id; logic [7:0] data; logic ovf; logic zero;} rsp_t;
  rsp_t exp_q[$];
  int got_ids[$];
  int mptr = 0;
  bit mbusy = 1'b0;
  int mcnt = 0;
  int checks = 0;
  int passes = 0;
  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) if (v[(p+k)%N]) return (p+k)%N;
    return -1;
  endfunction
  function automatic rsp_t model_rsp(int id, int op);
    rsp_t r;
    r.id = 2'(id);
    r.data = 8'((256 - op) % 256);
    r.ovf = op == 128;
    r.zero = op == 0;
    return r;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      exp_q.delete();
      mptr = 0;
      mbusy = 1'b0;
      mcnt = 0;
    end else if (!mbusy) begin
      w = pick(req_valid, mptr);
      if (w >= 0) begin
        exp_q.push_back(model_rsp(w, int'(req_data[8*w +: 8])));
        mptr = (w + 1) % N;
        mbusy = 1'b1;
      end
    end else if (rsp_ready) begin
      mbusy = 1'b0;
      mcnt = (mcnt + 1) % 65536;
    end
  end
  always @(negedge clk) begin
    int e;
    e = (rst_n && !mbusy) ? pick(req_valid, mptr) : -1;
    check("req_ready", 32'(req_ready), e < 0 ? 32'd0 : 32'd1 << e);
    check("rsp_valid", 32'(rsp_valid), 32'(mbusy));
    check("done_cnt", 32'(done_cnt), 32'(mcnt));
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
      end else begin
        check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
        check("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
        check("rsp_ovf", 32'(rsp_ovf), 32'(exp_q[0].ovf));
        check("rsp_zero", 32'(rsp_zero), 32'(exp_q[0].zero));
        if (rsp_ready) begin
          got_ids.push_back(int'(rsp_id));
          void'(exp_q.pop_front());
        end
      end
    end
  end
  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic req(int i, logic [7:0] d);
    req_data[8*i +: 8] = d;
    req_valid[i] = 1'b1;
  endtask
  task automatic wait_accept(int i);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        return;
      end
    end
    checks++;
    $display("FAIL accept_timeout: got no grant for requester %0d expected one within 40 cycles", i);
    req_valid[i] = 1'b0;
  endtask
  task automatic check_ids(string name, int e0, int e1, int e2, int e3, int n);
    int ex[4];
    ex = '{e0, e1, e2, e3};
    check({name, "_count"}, 32'(got_ids.size()), 32'(n));
    for (int i = 0; i < n; i++) if (i < got_ids.size()) check(name, 32'(got_ids[i]), 32'(ex[i]));
  endtask
  initial begin
    int k;
    logic [7:0] ops[5];
    #1 rst_n = 1'b0;
    rsp_ready = 1'b1;
    cycles(3);
    check("rst_id", 32'(rsp_id), 0);
    check("rst_data", 32'(rsp_data), 0);
    check("rst_ovf", 32'(rsp_ovf), 0);
    check("rst_zero", 32'(rsp_zero), 0);
    rst_n = 1'b1;
    cycles(1);
    got_ids.delete();
    req(2, 8'h05);
    wait_accept(2);
    cycles(2);
    check("single_cnt", 32'(done_cnt), 1);
    check_ids("single_id", 2, 0, 0, 0, 1);
    rst_n = 1'b0;
    cycles(2);
    req(0, 8'h01); req(1, 8'h02); req(2, 8'h03); req(3, 8'h04);
    got_ids.delete();
    rst_n = 1'b1;
    cycles(7);
    req_valid = '0;
    cycles(2);
    check_ids("rr_order", 0, 1, 2, 3, 4);
    got_ids.delete();
    req(0, 8'h10);
    req(3, 8'h30);
    wait_accept(0);
    req(1, 8'h20);
    wait_accept(1);
    wait_accept(3);
    cycles(2);
    check_ids("fair_order", 0, 1, 3, 0, 3);
    ops = '{8'h80, 8'h00, 8'h7F, 8'h01, 8'hFF};
    foreach (ops[i]) begin
      k = $urandom_range(0, N-1);
      req(k, ops[i]);
      wait_accept(k);
    end
    cycles(2);
    rsp_ready = 1'b0;
    req(1, 8'h11);
    req(2, 8'h22);
    wait_accept(1);
    cycles(5);
    k = mcnt;
    rsp_ready = 1'b1;
    cycles(1);
    check("bp_one_hs", 32'(done_cnt), 32'((k + 1) % 65536));
    wait_accept(2);
    cycles(2);
    rsp_ready = 1'b0;
    req(3, 8'h33);
    wait_accept(3);
    cycles(1);
    check("mid_valid", 32'(rsp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(rsp_valid), 0);
    check("arst_id", 32'(rsp_id), 0);
    check("arst_data", 32'(rsp_data), 0);
    check("arst_ovf", 32'(rsp_ovf), 0);
    check("arst_zero", 32'(rsp_zero), 0);
    check("arst_cnt", 32'(done_cnt), 0);
    req(1, 8'h44);
    req(3, 8'h55);
    #1 check("arst_ready", 32'(req_ready), 0);
    rsp_ready = 1'b1;
    cycles(2);
    got_ids.delete();
    rst_n = 1'b1;
    wait_accept(1);
    wait_accept(3);
    cycles(2);
    check_ids("post_rst", 1, 3, 0, 0, 2);
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      req_data = $urandom;
      rsp_ready = $urandom_range(0, 3) != 0;
      cycles(1);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    cycles(3);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/negate_arbiter.md
# negate_arbiter

Shares one 8-bit two's-complement negation unit (`twos_compliment`) between `N_REQ` requesters. Arbitration is round-robin with a valid/ready handshake on each request port and a single valid/ready response port. Exactly one operation is in flight at a time. The block instantiates the negator on its operand register and registers the result, overflow and zero flags for the downstream consumer.

## Interface
- `N_REQ`, default 4, number of requesters; legal range 2–8.
- `ID_W`, default 2, width of the requester index; must equal ceil(log2(`N_REQ`)).
- `clk`, input, 1, system clock; all state changes on the rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `req_valid`, input, `N_REQ`, per-requester operand valid.
- `req_data`, input, 8*`N_REQ`, operands; requester i occupies bits [8i+7:8i].
- `req_ready`, output, `N_REQ`, one-hot grant; a transfer occurs when `req_valid[i]` & `req_ready[i]` are both high.
- `rsp_valid`, output, 1, result available.
- `rsp_ready`, input, 1, consumer accepts the result.
- `rsp_id`, output, `ID_W`, index of the requester whose result is presented.
- `rsp_data`, output, 8, two's complement of the accepted operand, modulo 256.
- `rsp_ovf`, output, 1, the operand was 8'h80, so the result is 8'h80 and is unrepresentable.
- `rsp_zero`, output, 1, the operand was 8'h00.
- `done_cnt`, output, 16, count of completed response handshakes; wraps at 65535 → 0.

## Operation
- Two states: IDLE and RESP.
- IDLE:
  - `req_ready` is combinational.
  - Search `req_valid` starting at index `ptr` and moving upward with wrap; the first set bit wins.
  - Only the winner's `req_ready` is high; all other `req_ready` bits are 0.
  - If no requester is valid, `req_ready` = 0 and the state holds.
- On accept (requester w):
  - Register `req_data[w]` into the operand register and w into `rsp_id`.
  - The negator result is captured into `rsp_data`.
  - `rsp_ovf` = (operand == 8'h80); `rsp_zero` = (operand == 8'h00).
  - `ptr` ← (w+1) mod `N_REQ`.
  - Move to RESP.
- RESP:
  - `rsp_valid` = 1 and `req_ready` = 0 for all requesters.
  - `rsp_id`, `rsp_data`, `rsp_ovf` and `rsp_zero` hold stable until the handshake completes.
  - On `rsp_valid` & `rsp_ready`: `done_cnt` increments and the state returns to IDLE.
- Arithmetic is mod 256 and the negator's carry-out is discarded. Required mappings:
  - 8'h01 → 8'hFF
  - 8'h7F → 8'h81
  - 8'hFF → 8'h01
  - 8'h00 → 8'h00
- `ptr` advances only on an accept. It does not advance on idle cycles or on requests that are withdrawn.
- A requester may drop `req_valid` before it is accepted with no side effect. The grant then recomputes combinationally in the same cycle.
- `req_data` of non-granted requesters is ignored.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - State = IDLE, `ptr` = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 8'h00, `rsp_ovf` = 0, `rsp_zero` = 0.
  - `done_cnt` = 0, `req_ready` = 0.
- `req_ready` is gated by `rst_n` and is 0 whenever `rst_n` = 0.
- Latency: an accept at edge T produces `rsp_valid` = 1 in the cycle after edge T. Minimum latency is 1 cycle.
- Throughput:
  - The RESP handshake at edge T+1 gives IDLE in the next cycle.
  - The next accept can occur no earlier than edge T+2, so the maximum rate is one operation per 2 cycles.
  - There is no same-cycle response/accept bypass.
- `rsp_ready` held high before `rsp_valid` rises completes the handshake on the first RESP edge.
- Reset asserted while in RESP:
  - The in-flight result is dropped and `rsp_valid` falls immediately (asynchronous).
  - `done_cnt` is not incremented.
- `done_cnt` wrap: 16'hFFFF + 1 → 16'h0000 with no flag.

## Test plan
- Single request, index 2, operand 8'h05, `rsp_ready` = 1 → `req_ready` = 4'b0100 in the same cycle. `rsp_valid` the next cycle with `rsp_id` = 2, `rsp_data` = 8'hFB, `rsp_ovf` = 0, `rsp_zero` = 0. `done_cnt` = 1.
- All four requesters held valid from reset with operands 8'h01, 8'h02, 8'h03, 8'h04 and `rsp_ready` = 1 → grants in order 0, 1, 2, 3, one every 2 cycles. Results are 8'hFF, 8'hFE, 8'hFD, 8'hFC.
- Fairness wrap: after requester 3 is granted, requesters 0 and 3 are both valid → 0 is granted next. After 0, with 3 and 1 both valid → 1 is granted before 3.
- Boundary operands 8'h80, 8'h00 and 8'h7F → results 8'h80 with `rsp_ovf` = 1; 8'h00 with `rsp_zero` = 1; 8'h81 with both flags 0.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles while other requesters are valid → `rsp_*` stays stable, all `req_ready` = 0, and `done_cnt` is unchanged. Raising `rsp_ready` completes exactly one handshake.
- Pull `rst_n` low mid-RESP → `rsp_valid` = 0 asynchronously and all outputs return to their reset values. After release, the first grant goes to the lowest valid index because `ptr` = 0.
